// File: rtl/sm1118_color_freq_meter.sv
// TCS3200-style colour sensor frequency meter.
// Steps the photodiode filter through red, green and blue, counts synchronised
// sensor edges over a fixed gate window per colour, then reports the three
// counts and a dominant-colour code with a one-cycle valid pulse.
module sm1118_color_freq_meter #(
  parameter int unsigned GATE_CYCLES   = 50000,
  parameter int unsigned SETTLE_CYCLES = 500,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_COUNT     = 20
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cs_freq_in,
  output logic             s2,
  output logic             s3,
  output logic             busy,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [1:0]       color,
  output logic             valid
);

  localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Filter select codes as {S2,S3}
  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_R,
    ST_GATE_R,
    ST_SETTLE_G,
    ST_GATE_G,
    ST_SETTLE_B,
    ST_GATE_B,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic             w_tmr_done;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             w_edge;

  logic [CNT_W-1:0] r_work;
  logic [CNT_W-1:0] w_work_nxt;
  logic [CNT_W-1:0] r_hold_r;
  logic [CNT_W-1:0] r_hold_g;

  logic             w_in_gate;
  logic             w_nxt_gate;
  logic             w_nxt_settle;
  logic             w_state_chg;
  logic [1:0]       w_flt_nxt;

  logic [CNT_W-1:0] w_max;
  logic [1:0]       w_color_nxt;

  assign w_tmr_done  = (r_tmr == '0);
  assign w_edge      = r_sync2 & ~r_sync3;
  assign w_state_chg = (w_state_nxt != r_state);

  // Two-flop synchroniser for the asynchronous sensor output plus a history flop
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= cs_freq_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: settle then gate for each colour, one DONE cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (start)      w_state_nxt = ST_SETTLE_R;
      ST_SETTLE_R: if (w_tmr_done) w_state_nxt = ST_GATE_R;
      ST_GATE_R:   if (w_tmr_done) w_state_nxt = ST_SETTLE_G;
      ST_SETTLE_G: if (w_tmr_done) w_state_nxt = ST_GATE_G;
      ST_GATE_G:   if (w_tmr_done) w_state_nxt = ST_SETTLE_B;
      ST_SETTLE_B: if (w_tmr_done) w_state_nxt = ST_GATE_B;
      ST_GATE_B:   if (w_tmr_done) w_state_nxt = ST_DONE;
      ST_DONE:                     w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // State-class decode and the filter code belonging to the next state
  always_comb begin
    w_in_gate    = 1'b0;
    w_nxt_gate   = 1'b0;
    w_nxt_settle = 1'b0;
    w_flt_nxt    = FLT_CLEAR;
    case (r_state)
      ST_GATE_R, ST_GATE_G, ST_GATE_B: w_in_gate = 1'b1;
      default:                         w_in_gate = 1'b0;
    endcase
    case (w_state_nxt)
      ST_SETTLE_R: begin w_nxt_settle = 1'b1; w_flt_nxt = FLT_RED;   end
      ST_GATE_R:   begin w_nxt_gate   = 1'b1; w_flt_nxt = FLT_RED;   end
      ST_SETTLE_G: begin w_nxt_settle = 1'b1; w_flt_nxt = FLT_GREEN; end
      ST_GATE_G:   begin w_nxt_gate   = 1'b1; w_flt_nxt = FLT_GREEN; end
      ST_SETTLE_B: begin w_nxt_settle = 1'b1; w_flt_nxt = FLT_BLUE;  end
      ST_GATE_B:   begin w_nxt_gate   = 1'b1; w_flt_nxt = FLT_BLUE;  end
      default:     w_flt_nxt = FLT_CLEAR;
    endcase
  end

  // Shared down-counter, reloaded whenever the state changes
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_state_chg) begin
      if (w_nxt_settle) begin
        r_tmr <= SETTLE_LOAD;
      end else if (w_nxt_gate) begin
        r_tmr <= GATE_LOAD;
      end else begin
        r_tmr <= '0;
      end
    end else if (!w_tmr_done) begin
      r_tmr <= r_tmr - TMR_W'(1);
    end
  end

  // Saturating edge count including any edge pulse in the current gate cycle
  always_comb begin
    w_work_nxt = r_work;
    if (w_in_gate && w_edge && (r_work != CNT_MAX)) begin
      w_work_nxt = r_work + CNT_W'(1);
    end
  end

  // Working counter: cleared on gate entry, counts edge pulses while gating
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
    end else if (w_state_chg && w_nxt_gate) begin
      r_work <= '0;
    end else begin
      r_work <= w_work_nxt;
    end
  end

  // Per-colour holding registers latched as each gate window closes
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_r <= '0;
      r_hold_g <= '0;
    end else if (w_in_gate && w_state_chg) begin
      if (r_state == ST_GATE_R) begin
        r_hold_r <= w_work_nxt;
      end
      if (r_state == ST_GATE_G) begin
        r_hold_g <= w_work_nxt;
      end
    end
  end

  // Dominant colour; blue comes straight from the closing gate window
  always_comb begin
    w_max = r_hold_r;
    if (r_hold_g > w_max) begin
      w_max = r_hold_g;
    end
    if (w_work_nxt > w_max) begin
      w_max = w_work_nxt;
    end
    if (32'(w_max) < MIN_COUNT) begin
      w_color_nxt = COL_NONE;
    end else if ((r_hold_r >= r_hold_g) && (r_hold_r >= w_work_nxt)) begin
      w_color_nxt = COL_RED;
    end else if (r_hold_g >= w_work_nxt) begin
      w_color_nxt = COL_GREEN;
    end else begin
      w_color_nxt = COL_BLUE;
    end
  end

  // Registered outputs: filter and busy follow the next state, results on DONE entry
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      s2        <= FLT_CLEAR[1];
      s3        <= FLT_CLEAR[0];
      busy      <= 1'b0;
      valid     <= 1'b0;
      red_cnt   <= '0;
      green_cnt <= '0;
      blue_cnt  <= '0;
      color     <= COL_NONE;
    end else begin
      s2    <= w_flt_nxt[1];
      s3    <= w_flt_nxt[0];
      busy  <= (w_state_nxt != ST_IDLE);
      valid <= (w_state_nxt == ST_DONE);
      if ((r_state == ST_GATE_B) && (w_state_nxt == ST_DONE)) begin
        red_cnt   <= r_hold_r;
        green_cnt <= r_hold_g;
        blue_cnt  <= w_work_nxt;
        color     <= w_color_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sm1118_color_freq_meter.sv
// Bench for sm1118_color_freq_meter: directed table, saturation, start-ignore,
// mid-measurement reset and randomized runs against a window-counting model.
module tb_sm1118_color_freq_meter;

  localparam int G    = 100;
  localparam int S    = 10;
  localparam int MINC = 5;
  localparam int LAT  = 3 * (S + G) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic start8, start5;
  logic cs;

  logic       s2_8, s3_8, busy8, valid8;
  logic [7:0] red8, green8, blue8;
  logic [1:0] color8;
  logic       s2_5, s3_5, busy5, valid5;
  logic [4:0] red5, green5, blue5;
  logic [1:0] color5;

  int cyc = 0;
  int E   = -100000;
  int mcnt[3];
  int per[4];
  int off[4];
  bit sel5 = 1'b0;
  logic [1:0] prev_code = 2'b10;
  int ph = 0;
  int n_pass = 0;
  int n_chk  = 0;

  sm1118_color_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8), .MIN_COUNT(MINC)) u_dut8 (
    .clk_50M(clk), .rst_n(rst_n), .start(start8), .cs_freq_in(cs),
    .s2(s2_8), .s3(s3_8), .busy(busy8),
    .red_cnt(red8), .green_cnt(green8), .blue_cnt(blue8),
    .color(color8), .valid(valid8));

  sm1118_color_freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(5), .MIN_COUNT(MINC)) u_dut5 (
    .clk_50M(clk), .rst_n(rst_n), .start(start5), .cs_freq_in(cs),
    .s2(s2_5), .s3(s3_5), .busy(busy5),
    .red_cnt(red5), .green_cnt(green5), .blue_cnt(blue5),
    .color(color5), .valid(valid5));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sensor stimulus: period chosen by the active filter, phase restarts on filter change.
  // Model: a rise driven now is sampled at edge cyc+1 and its pulse lands in the cycle
  // whose state was set at edge cyc+2; count it if that cycle lies in a gate window.
  always @(negedge clk) begin : gen
    logic [1:0] code;
    int idx;
    logic nv;
    int p1;
    int gs;
    code = sel5 ? {s2_5, s3_5} : {s2_8, s3_8};
    if (code != prev_code) ph = 0;
    else ph = ph + 1;
    prev_code = code;
    case (code)
      2'b00:   idx = 0;
      2'b11:   idx = 1;
      2'b01:   idx = 2;
      default: idx = 3;
    endcase
    if (per[idx] >= 2) nv = (((ph + off[idx]) % per[idx]) < (per[idx] / 2));
    else nv = 1'b0;
    if (nv && !cs) begin
      p1 = cyc + 2;
      for (int c = 0; c < 3; c++) begin
        gs = E + S + c * (S + G);
        if (p1 >= gs && p1 <= gs + G - 1) mcnt[c] = mcnt[c] + 1;
      end
    end
    cs = nv;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int ref_color(input int r, input int g, input int b);
    int m;
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    if (m < MINC) return 0;
    if (r >= g && r >= b) return 1;
    if (g >= b) return 2;
    return 3;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // One measurement; observes 400 cycles after start. poke adds a start at 50
  // cycles in and another during the DONE cycle, both of which must be ignored.
  task automatic run_meas(input bit use5, input bit poke, output int lat, output int nv,
                          output logic bsy_v, output logic bsy_a);
    int t0;
    logic v;
    @(negedge clk);
    sel5 = use5;
    @(negedge clk);
    t0 = cyc;
    E  = cyc + 1;
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
    if (use5) start5 = 1'b1;
    else start8 = 1'b1;
    lat = -1; nv = 0; bsy_v = 1'b0; bsy_a = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) begin start5 = 1'b0; start8 = 1'b0; end
      if (poke && i == 50) start8 = 1'b1;
      if (poke && i == 51) start8 = 1'b0;
      if (lat >= 0 && cyc == t0 + lat + 1) begin
        bsy_a  = use5 ? busy5 : busy8;
        start8 = 1'b0;
      end
      v = use5 ? valid5 : valid8;
      if (v) begin
        nv++;
        if (lat < 0) begin
          lat   = cyc - t0;
          bsy_v = use5 ? busy5 : busy8;
          if (poke) start8 = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    string nm;
    int pr, pg, pb;
    int er, eg, eb;
    int ecol;
  } vec_t;

  initial begin
    vec_t vt[3];
    int lat, nv;
    logic bv, ba;
    int r, g, b, col;

    vt[0] = '{"red_dom", 10, 20, 25, 10, 5, 4, 1};
    vt[1] = '{"dark",     0,  0,  0,  0, 0, 0, 0};
    vt[2] = '{"tie_gb",  40,  8,  8,  2, 12, 12, 2};

    for (int i = 0; i < 4; i++) begin per[i] = 0; off[i] = 0; end
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
    rst_n = 1'b0; start8 = 1'b0; start5 = 1'b0; cs = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", int'(busy8), 0);
    chk("rst_s2s3", int'({s2_8, s3_8}), 2);
    chk("rst_valid", int'(valid8), 0);
    chk("rst_cnts", int'(red8) + int'(green8) + int'(blue8), 0);
    chk("rst_color", int'(color8), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    for (int k = 0; k < 3; k++) begin
      per[0] = vt[k].pr; per[1] = vt[k].pg; per[2] = vt[k].pb; per[3] = 0;
      for (int i = 0; i < 4; i++) off[i] = 0;
      run_meas(1'b0, 1'b0, lat, nv, bv, ba);
      r = int'(red8); g = int'(green8); b = int'(blue8); col = int'(color8);
      chk({vt[k].nm, "_lat"}, lat, LAT);
      chk({vt[k].nm, "_nvalid"}, nv, 1);
      chk({vt[k].nm, "_busy_done"}, int'(bv), 1);
      chk({vt[k].nm, "_busy_after"}, int'(ba), 0);
      chk_rng({vt[k].nm, "_red"}, r, vt[k].er - 1, vt[k].er + 1);
      chk_rng({vt[k].nm, "_green"}, g, vt[k].eg - 1, vt[k].eg + 1);
      chk_rng({vt[k].nm, "_blue"}, b, vt[k].eb - 1, vt[k].eb + 1);
      chk({vt[k].nm, "_color"}, col, vt[k].ecol);
      chk({vt[k].nm, "_red_model"}, r, sat(mcnt[0], 8));
      chk({vt[k].nm, "_green_model"}, g, sat(mcnt[1], 8));
      chk({vt[k].nm, "_blue_model"}, b, sat(mcnt[2], 8));
    end
    chk("tie_green_eq_blue", int'(green8), int'(blue8));

    // Saturation on the 5-bit instance with the input toggling every cycle
    per[0] = 2; per[1] = 2; per[2] = 2;
    run_meas(1'b1, 1'b0, lat, nv, bv, ba);
    chk("sat_lat", lat, LAT);
    chk("sat_red", int'(red5), 31);
    chk("sat_green", int'(green5), 31);
    chk("sat_blue", int'(blue5), 31);
    chk("sat_color", int'(color5), 1);
    chk("sat_model_red", int'(red5), sat(mcnt[0], 5));

    // Start while busy and start during DONE are both ignored
    per[0] = 12; per[1] = 30; per[2] = 9;
    run_meas(1'b0, 1'b1, lat, nv, bv, ba);
    chk("ign_lat", lat, LAT);
    chk("ign_nvalid", nv, 1);
    chk("ign_busy_after", int'(ba), 0);
    chk("ign_color", int'(color8), 3);

    // Randomized measurements against the window model
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) begin
        per[c] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(2, 45));
        off[c] = int'($urandom_range(0, 44));
      end
      run_meas(1'b0, 1'b0, lat, nv, bv, ba);
      r = sat(mcnt[0], 8); g = sat(mcnt[1], 8); b = sat(mcnt[2], 8);
      chk($sformatf("rnd%0d_lat", k), lat, LAT);
      chk($sformatf("rnd%0d_nvalid", k), nv, 1);
      chk($sformatf("rnd%0d_red", k), int'(red8), r);
      chk($sformatf("rnd%0d_green", k), int'(green8), g);
      chk($sformatf("rnd%0d_blue", k), int'(blue8), b);
      chk($sformatf("rnd%0d_color", k), int'(color8), ref_color(r, g, b));
    end

    // Reset in the middle of GATE_G aborts the measurement
    per[0] = 10; per[1] = 10; per[2] = 10;
    @(negedge clk);
    sel5 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (170) @(negedge clk);
    chk("mid_busy", int'(busy8), 1);
    chk("mid_s2s3_green", int'({s2_8, s3_8}), 3);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_s2s3", int'({s2_8, s3_8}), 2);
    chk("abort_cnts", int'(red8) + int'(green8) + int'(blue8), 0);
    chk("abort_color", int'(color8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid8) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_idle_busy", int'(busy8), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
